// File: rtl/bus_rr_xbar.sv
// bus_rr_xbar: round-robin request/grant crossbar between NrHosts hosts and
// NrDevices memory-mapped devices.
//
// Grants are issued in the same cycle as the request. Each grant records
// {host, target} in an in-order tracking FIFO. Responses are routed back to
// hosts in grant order, taken from the FIFO head. Addresses that match no
// device are answered internally with an error response.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   host_req_i/gnt_o       per-host request and combinational grant
//   host_addr/we/be/wdata  per-host request fields (flattened, host 0 in LSBs)
//   host_rvalid/rdata/err  per-host response
//   device_req_o           one-cycle request pulse to the decoded device
//   device_addr/we/be/wdata  granted host's fields, broadcast to all devices
//   device_rvalid/rdata/err  per-device response inputs
//   cfg_device_addr_base/mask  per-device address decode window
//   protocol_err_o         sticky flag for device responses nobody expected
module bus_rr_xbar #(
  parameter int NrHosts        = 2,
  parameter int NrDevices      = 8,
  parameter int DataWidth      = 32,
  parameter int AddressWidth   = 32,
  parameter int MaxOutstanding = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NrHosts-1:0]               host_req_i,
  output logic [NrHosts-1:0]               host_gnt_o,
  input  logic [NrHosts*AddressWidth-1:0]  host_addr_i,
  input  logic [NrHosts-1:0]               host_we_i,
  input  logic [NrHosts*DataWidth/8-1:0]   host_be_i,
  input  logic [NrHosts*DataWidth-1:0]     host_wdata_i,
  output logic [NrHosts-1:0]               host_rvalid_o,
  output logic [NrHosts*DataWidth-1:0]     host_rdata_o,
  output logic [NrHosts-1:0]               host_err_o,
  output logic [NrDevices-1:0]             device_req_o,
  output logic [AddressWidth-1:0]          device_addr_o,
  output logic                             device_we_o,
  output logic [DataWidth/8-1:0]           device_be_o,
  output logic [DataWidth-1:0]             device_wdata_o,
  input  logic [NrDevices-1:0]             device_rvalid_i,
  input  logic [NrDevices*DataWidth-1:0]   device_rdata_i,
  input  logic [NrDevices-1:0]             device_err_i,
  input  logic [NrDevices*AddressWidth-1:0] cfg_device_addr_base,
  input  logic [NrDevices*AddressWidth-1:0] cfg_device_addr_mask,
  output logic                             protocol_err_o
);

  localparam int BeWidth = DataWidth / 8;
  localparam int HostW   = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  // One extra target code beyond the real devices names the error responder.
  localparam int TgtW    = $clog2(NrDevices + 1);
  localparam int PtrW    = $clog2(MaxOutstanding);
  localparam int CntW    = PtrW + 1;
  localparam logic [TgtW-1:0] ErrTgt = TgtW'(NrDevices);

  logic [HostW-1:0]        rr_ptr;
  logic                    found;
  logic [HostW-1:0]        winner;
  logic [AddressWidth-1:0] win_addr;
  logic [TgtW-1:0]         win_tgt;
  logic                    grant;

  logic [HostW-1:0]        fifo_host [MaxOutstanding];
  logic [TgtW-1:0]         fifo_tgt  [MaxOutstanding];
  logic [PtrW-1:0]         wr_ptr;
  logic [PtrW-1:0]         rd_ptr;
  logic [CntW-1:0]         count;
  logic [TgtW-1:0]         last_tgt;
  logic                    fifo_empty;
  logic                    fifo_full;

  logic [HostW-1:0]        head_host;
  logic [TgtW-1:0]         head_tgt;
  logic                    head_is_err;
  logic                    head_rvalid;
  logic [DataWidth-1:0]    head_rdata;
  logic                    head_err;
  logic                    stray;
  logic                    pop;

  function automatic logic [HostW-1:0] host_at(input logic [HostW-1:0] base, input int k);
    int sum;
    sum = (int'(base) + k) % NrHosts;
    return HostW'(sum);
  endfunction

  // Round-robin: scan from the host after the last granted one.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= NrHosts; k++) begin
      if (!found && host_req_i[host_at(rr_ptr, k)]) begin
        found  = 1'b1;
        winner = host_at(rr_ptr, k);
      end
    end
  end

  assign win_addr = host_addr_i[int'(winner)*AddressWidth +: AddressWidth];

  // Scan downwards so the lowest matching device index has the final say.
  always_comb begin
    win_tgt = ErrTgt;
    for (int d = NrDevices - 1; d >= 0; d--) begin
      if ((win_addr & cfg_device_addr_mask[d*AddressWidth +: AddressWidth]) ==
          cfg_device_addr_base[d*AddressWidth +: AddressWidth]) begin
        win_tgt = TgtW'(d);
      end
    end
  end

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CntW'(MaxOutstanding));

  // Switching target is only safe once everything in flight has returned,
  // otherwise two devices could answer out of order. A pop this cycle does
  // not count toward freeing space or emptying the FIFO.
  assign grant = rst_ni && found && !fifo_full && (fifo_empty || (win_tgt == last_tgt));

  always_comb begin
    host_gnt_o     = '0;
    device_req_o   = '0;
    device_addr_o  = '0;
    device_we_o    = 1'b0;
    device_be_o    = '0;
    device_wdata_o = '0;
    if (grant) begin
      host_gnt_o[winner] = 1'b1;
      for (int d = 0; d < NrDevices; d++) begin
        device_req_o[d] = (win_tgt == TgtW'(d));
      end
      device_addr_o  = win_addr;
      device_we_o    = host_we_i[winner];
      device_be_o    = host_be_i[int'(winner)*BeWidth +: BeWidth];
      device_wdata_o = host_wdata_i[int'(winner)*DataWidth +: DataWidth];
    end
  end

  assign head_host   = fifo_host[rd_ptr];
  assign head_tgt    = fifo_tgt[rd_ptr];
  assign head_is_err = !fifo_empty && (head_tgt == ErrTgt);

  // Pick out the head device's response; any other device raising rvalid
  // is answering a request we never sent it.
  always_comb begin
    head_rvalid = 1'b0;
    head_rdata  = '0;
    head_err    = 1'b0;
    stray       = 1'b0;
    for (int d = 0; d < NrDevices; d++) begin
      if (!fifo_empty && (head_tgt == TgtW'(d))) begin
        head_rvalid = device_rvalid_i[d];
        head_rdata  = device_rdata_i[d*DataWidth +: DataWidth];
        head_err    = device_err_i[d];
      end else if (device_rvalid_i[d]) begin
        stray = 1'b1;
      end
    end
  end

  // The error responder answers in the first cycle its entry is at the head.
  assign pop = head_is_err || head_rvalid;

  always_comb begin
    host_rvalid_o = '0;
    host_err_o    = '0;
    host_rdata_o  = '0;
    if (pop) begin
      host_rvalid_o[head_host] = 1'b1;
      host_err_o[head_host]    = head_is_err | head_err;
      host_rdata_o[int'(head_host)*DataWidth +: DataWidth] = head_rdata;
    end
  end

  // FIFO storage carries no reset; validity is defined by count.
  always_ff @(posedge clk_i) begin
    if (grant) begin
      fifo_host[wr_ptr] <= winner;
      fifo_tgt[wr_ptr]  <= win_tgt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr         <= HostW'(NrHosts - 1);
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      last_tgt       <= '0;
      protocol_err_o <= 1'b0;
    end else begin
      if (grant) begin
        wr_ptr   <= wr_ptr + 1'b1;
        rr_ptr   <= winner;
        last_tgt <= win_tgt;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (grant && !pop) begin
        count <= count + 1'b1;
      end else if (!grant && pop) begin
        count <= count - 1'b1;
      end
      if (stray) begin
        protocol_err_o <= 1'b1;
      end
    end
  end

endmodule
